// File: rtl/sample_memory_scheduler_if.sv
// Memory port bundle between the sample scheduler and the sample SRAM.
// Master issues requests, slave accepts them and returns read data.
interface sample_memory_scheduler_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/sample_memory_scheduler.sv
// Per-sample sequencer for the shared sample SRAM: one write into a
// circular delay buffer, then NUM_TAPS delayed reads streamed to the MAC.
module sample_memory_scheduler #(
    parameter int               ADDR_W   = 16,
    parameter int               DATA_W   = 16,
    parameter int               NUM_TAPS = 4,
    parameter logic [ADDR_W-1:0] BUF_BASE = 16'h0200,
    parameter logic [ADDR_W-1:0] BUF_TOP  = 16'hFFFE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_stb,
    input  logic [DATA_W-1:0]          sample_in,
    input  logic                       record_en,
    input  logic [NUM_TAPS*ADDR_W-1:0] tap_delay,
    sample_memory_scheduler_if.master  mem,
    output logic                       tap_valid,
    output logic [3:0]                 tap_index,
    output logic [DATA_W-1:0]          tap_data,
    output logic                       frame_done,
    output logic                       busy,
    output logic                       overrun
);

    localparam logic [ADDR_W:0] LEN    = {1'b0, BUF_TOP} - {1'b0, BUF_BASE} + 1'b1;
    localparam logic [ADDR_W:0] LEN_M1 = LEN - 1'b1;
    localparam logic [3:0]      LAST   = 4'(NUM_TAPS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_REQ,
        READ_WAIT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [3:0]        tap_q, tap_d;
    logic              pend_full_q, pend_full_d;
    logic [DATA_W-1:0] pend_sample_q, pend_sample_d;
    logic              pend_rec_q, pend_rec_d;
    logic [DATA_W-1:0] frm_sample_q, frm_sample_d;
    logic              frm_rec_q, frm_rec_d;
    logic              overrun_q, overrun_d;
    logic              tap_valid_q, tap_valid_d;
    logic [3:0]        tap_index_q, tap_index_d;
    logic [DATA_W-1:0] tap_data_q, tap_data_d;

    logic [3:0]        tap_sel;
    logic [ADDR_W-1:0] raw_dly;
    logic [ADDR_W:0]   dly;
    logic [ADDR_W:0]   off;
    logic [ADDR_W-1:0] rd_calc;

    logic              req_c;
    logic              we_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c;

    // Tap whose read address is latched when READ_REQ is next entered.
    always_comb begin
        tap_sel = 4'd0;
        if (state_q == READ_WAIT) begin
            tap_sel = tap_q + 4'd1;
        end
    end

    // Clamped delay and wrap-safe backwards offset from the write pointer.
    always_comb begin
        raw_dly = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (tap_sel == i[3:0]) begin
                raw_dly = tap_delay[i*ADDR_W +: ADDR_W];
            end
        end
        dly = ({1'b0, raw_dly} > LEN_M1) ? LEN_M1 : {1'b0, raw_dly};
        off = {1'b0, wr_ptr_q} - {1'b0, BUF_BASE};
        if (off >= dly) begin
            rd_calc = ADDR_W'({1'b0, wr_ptr_q} - dly);
        end else begin
            rd_calc = ADDR_W'({1'b0, wr_ptr_q} + LEN - dly);
        end
    end

    // Pending-slot capture, frame FSM next state and memory request outputs.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_addr_d     = rd_addr_q;
        tap_d         = tap_q;
        pend_full_d   = pend_full_q;
        pend_sample_d = pend_sample_q;
        pend_rec_d    = pend_rec_q;
        frm_sample_d  = frm_sample_q;
        frm_rec_d     = frm_rec_q;
        overrun_d     = overrun_q;
        tap_valid_d   = 1'b0;
        tap_index_d   = tap_index_q;
        tap_data_d    = tap_data_q;
        req_c         = 1'b0;
        we_c          = 1'b0;
        addr_c        = '0;
        wdata_c       = '0;

        if (state_q == IDLE && pend_full_q) begin
            pend_full_d = 1'b0;
        end
        if (sample_stb) begin
            if (pend_full_d) begin
                overrun_d = 1'b1;
            end else begin
                pend_full_d   = 1'b1;
                pend_sample_d = sample_in;
                pend_rec_d    = record_en;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (pend_full_q) begin
                    frm_sample_d = pend_sample_q;
                    frm_rec_d    = pend_rec_q;
                    tap_d        = 4'd0;
                    if (pend_rec_q) begin
                        state_d = WRITE;
                    end else begin
                        state_d   = READ_REQ;
                        rd_addr_d = rd_calc;
                    end
                end
            end
            WRITE: begin
                req_c   = 1'b1;
                we_c    = 1'b1;
                addr_c  = wr_ptr_q;
                wdata_c = frm_sample_q;
                if (mem.mem_ready) begin
                    state_d   = READ_REQ;
                    tap_d     = 4'd0;
                    rd_addr_d = rd_calc;
                end
            end
            READ_REQ: begin
                req_c  = 1'b1;
                addr_c = rd_addr_q;
                if (mem.mem_ready) begin
                    state_d = READ_WAIT;
                end
            end
            READ_WAIT: begin
                if (mem.mem_rvalid) begin
                    tap_valid_d = 1'b1;
                    tap_index_d = tap_q;
                    tap_data_d  = mem.mem_rdata;
                    if (tap_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        tap_d     = tap_q + 4'd1;
                        rd_addr_d = rd_calc;
                        state_d   = READ_REQ;
                    end
                end
            end
            DONE: begin
                if (frm_rec_q) begin
                    wr_ptr_d = (wr_ptr_q == BUF_TOP) ? BUF_BASE : wr_ptr_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= BUF_BASE;
            rd_addr_q     <= '0;
            tap_q         <= '0;
            pend_full_q   <= 1'b0;
            pend_sample_q <= '0;
            pend_rec_q    <= 1'b0;
            frm_sample_q  <= '0;
            frm_rec_q     <= 1'b0;
            overrun_q     <= 1'b0;
            tap_valid_q   <= 1'b0;
            tap_index_q   <= '0;
            tap_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_addr_q     <= rd_addr_d;
            tap_q         <= tap_d;
            pend_full_q   <= pend_full_d;
            pend_sample_q <= pend_sample_d;
            pend_rec_q    <= pend_rec_d;
            frm_sample_q  <= frm_sample_d;
            frm_rec_q     <= frm_rec_d;
            overrun_q     <= overrun_d;
            tap_valid_q   <= tap_valid_d;
            tap_index_q   <= tap_index_d;
            tap_data_q    <= tap_data_d;
        end
    end

    assign mem.mem_req   = req_c;
    assign mem.mem_we    = we_c;
    assign mem.mem_addr  = addr_c;
    assign mem.mem_wdata = wdata_c;

    assign tap_valid  = tap_valid_q;
    assign tap_index  = tap_index_q;
    assign tap_data   = tap_data_q;
    assign frame_done = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sample_memory_scheduler.sv
// Bench for sample_memory_scheduler: SRAM model plus request/tap scoreboard.
// Expected requests and taps are queued when a strobe is driven.
module tb_sample_memory_scheduler;

    localparam logic [15:0] BASE = 16'h0200;
    localparam logic [15:0] TOP  = 16'hFFFE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_stb = 1'b0;
    logic [15:0] sample_in = '0;
    logic        record_en = 1'b0;
    logic [63:0] tap_delay = '0;
    logic        tap_valid;
    logic [3:0]  tap_index;
    logic [15:0] tap_data;
    logic        frame_done;
    logic        busy;
    logic        overrun;

    sample_memory_scheduler_if #(.ADDR_W(16), .DATA_W(16)) m ();

    sample_memory_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .sample_stb (sample_stb),
        .sample_in  (sample_in),
        .record_en  (record_en),
        .tap_delay  (tap_delay),
        .mem        (m.master),
        .tap_valid  (tap_valid),
        .tap_index  (tap_index),
        .tap_data   (tap_data),
        .frame_done (frame_done),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } req_t;

    int          checks = 0;
    int          failures = 0;
    int          frames = 0;
    int          lat = 1;
    int          rcnt = 0;
    logic [15:0] rbuf;
    logic [15:0] mem [0:65535];
    logic [15:0] shadow [0:65535];
    logic [15:0] mwr;
    req_t        exp_req [$];
    logic [19:0] exp_tap [$];
    logic [15:0] log_addr [$];
    logic        log_we [$];
    logic [15:0] log_tap [$];
    req_t        e;
    logic [19:0] et;

    // SRAM model: writes land at accept, read data returns lat cycles later.
    always @(posedge clk) begin
        m.mem_rvalid <= 1'b0;
        if (rcnt > 0) begin
            rcnt <= rcnt - 1;
            if (rcnt == 1) begin
                m.mem_rvalid <= 1'b1;
                m.mem_rdata  <= rbuf;
            end
        end
        if (m.mem_req && m.mem_ready) begin
            if (m.mem_we) begin
                mem[m.mem_addr] <= m.mem_wdata;
            end else if (lat <= 1) begin
                m.mem_rvalid <= 1'b1;
                m.mem_rdata  <= mem[m.mem_addr];
            end else begin
                rbuf <= mem[m.mem_addr];
                rcnt <= lat - 1;
            end
        end
    end

    // Scoreboard: compare accepted requests and emitted taps against the queues.
    always @(negedge clk) begin
        if (!rst && m.mem_req && m.mem_ready) begin
            checks++;
            log_addr.push_back(m.mem_addr);
            log_we.push_back(m.mem_we);
            if (exp_req.size() == 0) begin
                failures++;
                $display("FAIL req_unexpected we=%0b addr=%h", m.mem_we, m.mem_addr);
            end else begin
                e = exp_req.pop_front();
                if (m.mem_we !== e.we || m.mem_addr !== e.addr ||
                    (e.we && m.mem_wdata !== e.data)) begin
                    failures++;
                    $display("FAIL req got we=%0b addr=%h wd=%h exp we=%0b addr=%h wd=%h",
                             m.mem_we, m.mem_addr, m.mem_wdata, e.we, e.addr, e.data);
                end
            end
        end
        if (!rst && tap_valid) begin
            checks++;
            log_tap.push_back(tap_data);
            if (exp_tap.size() == 0) begin
                failures++;
                $display("FAIL tap_unexpected idx=%0d data=%h", tap_index, tap_data);
            end else begin
                et = exp_tap.pop_front();
                if ({tap_index, tap_data} !== et) begin
                    failures++;
                    $display("FAIL tap got idx=%0d data=%h exp idx=%0d data=%h",
                             tap_index, tap_data, et[19:16], et[15:0]);
                end
            end
        end
        if (!rst && frame_done) begin
            frames++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_we.delete();
        log_tap.delete();
    endtask

    // Reference model: walk back d slots around the ring from the write pointer.
    task automatic push_frame(input logic [15:0] s, input logic rec);
        logic [15:0] raw;
        int          d;
        logic [15:0] a;
        if (rec) begin
            exp_req.push_back({1'b1, mwr, s});
            shadow[mwr] = s;
        end
        for (int i = 0; i < 4; i++) begin
            raw = tap_delay[i*16 +: 16];
            d = (int'(raw) > 32'h0FDFE) ? 32'h0FDFE : int'(raw);
            a = mwr;
            for (int k = 0; k < d; k++) begin
                a = (a == BASE) ? TOP : a - 16'd1;
            end
            exp_req.push_back({1'b0, a, 16'h0000});
            exp_tap.push_back({4'(i), shadow[a]});
        end
        if (rec) begin
            mwr = (mwr == TOP) ? BASE : mwr + 16'd1;
        end
    endtask

    task automatic pulse(input logic [15:0] s, input logic rec);
        sample_in  = s;
        record_en  = rec;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
    endtask

    task automatic strobe(input logic [15:0] s, input logic rec);
        push_frame(s, rec);
        pulse(s, rec);
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames < target && n < 400) begin
            tick();
            n++;
        end
        tick();
        tick();
        checks++;
        if (frames < target) begin
            failures++;
            $display("FAIL frame_timeout frames=%0d need=%0d", frames, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({m.mem_req, m.mem_we, m.mem_addr, m.mem_wdata} !== 34'h0) begin
            failures++;
            $display("FAIL reset_mem req=%0b we=%0b addr=%h wd=%h", m.mem_req,
                     m.mem_we, m.mem_addr, m.mem_wdata);
        end
        checks++;
        if ({tap_valid, tap_index, tap_data, frame_done, busy, overrun} !== 25'h0) begin
            failures++;
            $display("FAIL reset_out tv=%0b ti=%0d td=%h fd=%0b busy=%0b ovr=%0b",
                     tap_valid, tap_index, tap_data, frame_done, busy, overrun);
        end
        rst = 1'b0;
        mwr = BASE;
        tick();
    endtask

    task automatic test_basic();
        int f = frames;
        logic [15:0] ea [5];
        ea = '{16'h0200, 16'h0200, 16'hFFFE, 16'hFFFD, 16'hFFFC};
        tap_delay = {16'd3, 16'd2, 16'd1, 16'd0};
        clear_logs();
        strobe(16'h1234, 1'b1);
        wait_frames(f + 1);
        checks++;
        if (log_addr.size() != 5) begin
            failures++;
            $display("FAIL basic_req_count got=%0d exp=5", log_addr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (log_addr[i] !== ea[i]) begin
                    failures++;
                    $display("FAIL basic_addr%0d got=%h exp=%h", i, log_addr[i], ea[i]);
                end
            end
        end
        checks++;
        if (log_tap.size() == 0 || log_tap[0] !== 16'h1234) begin
            failures++;
            $display("FAIL basic_tap0 got=%h exp=1234",
                     log_tap.size() ? log_tap[0] : 16'hxxxx);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy got=%0b exp=0", busy);
        end
    endtask

    task automatic test_wrap();
        int f = frames;
        force dut.wr_ptr_q = 16'hFFFE;
        tick();
        tick();
        release dut.wr_ptr_q;
        mwr = 16'hFFFE;
        tap_delay = {16'd3, 16'd2, 16'd1, 16'd0};
        clear_logs();
        strobe(16'hBEEF, 1'b1);
        wait_frames(f + 1);
        checks++;
        if (log_addr.size() == 0 || log_addr[0] !== 16'hFFFE) begin
            failures++;
            $display("FAIL wrap_write got=%h exp=fffe",
                     log_addr.size() ? log_addr[0] : 16'hxxxx);
        end
        tap_delay = {16'd0, 16'd0, 16'd0, 16'd1};
        clear_logs();
        strobe(16'hC0DE, 1'b1);
        wait_frames(f + 2);
        checks++;
        if (log_addr.size() < 2 || log_addr[0] !== 16'h0200 || log_addr[1] !== 16'hFFFE) begin
            failures++;
            $display("FAIL wrap_next got=%h,%h exp=0200,fffe",
                     log_addr.size() > 0 ? log_addr[0] : 16'hxxxx,
                     log_addr.size() > 1 ? log_addr[1] : 16'hxxxx);
        end
        checks++;
        if (log_tap.size() == 0 || log_tap[0] !== 16'hBEEF) begin
            failures++;
            $display("FAIL wrap_tap0 got=%h exp=beef",
                     log_tap.size() ? log_tap[0] : 16'hxxxx);
        end
    endtask

    task automatic test_stall();
        int f = frames;
        tap_delay = {16'd3, 16'd2, 16'd1, 16'd0};
        clear_logs();
        m.mem_ready = 1'b0;
        strobe(16'h5A5A, 1'b1);
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({m.mem_req, m.mem_we, m.mem_addr, m.mem_wdata, tap_valid} !==
                {1'b1, 1'b1, 16'h0201, 16'h5A5A, 1'b0}) begin
                failures++;
                $display("FAIL stall_c%0d req=%0b we=%0b addr=%h wd=%h tv=%0b exp 1 1 0201 5a5a 0",
                         c, m.mem_req, m.mem_we, m.mem_addr, m.mem_wdata, tap_valid);
            end
            tick();
        end
        m.mem_ready = 1'b1;
        wait_frames(f + 1);
    endtask

    task automatic test_back_to_back();
        int f = frames;
        tap_delay = {16'd7, 16'd5, 16'd2, 16'd0};
        clear_logs();
        strobe(16'hA001, 1'b1);
        tick();
        strobe(16'hA002, 1'b1);
        tick();
        pulse(16'hA003, 1'b1);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL b2b_overrun got=%0b exp=1", overrun);
        end
        wait_frames(f + 2);
        for (int c = 0; c < 20; c++) begin
            tick();
        end
        checks++;
        if (frames != f + 2 || log_tap.size() != 8) begin
            failures++;
            $display("FAIL b2b_frames got=%0d taps=%0d exp=%0d taps=8", frames,
                     log_tap.size(), f + 2);
        end
    endtask

    task automatic test_freeze();
        int f = frames;
        int nwe = 0;
        tap_delay = {16'd3, 16'd2, 16'd1, 16'd0};
        clear_logs();
        strobe(16'h7777, 1'b0);
        wait_frames(f + 1);
        foreach (log_we[i]) begin
            if (log_we[i]) nwe++;
        end
        checks++;
        if (nwe != 0 || log_addr.size() != 4 || log_tap.size() != 4) begin
            failures++;
            $display("FAIL freeze writes=%0d reqs=%0d taps=%0d exp 0 4 4", nwe,
                     log_addr.size(), log_tap.size());
        end
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL freeze_overrun_sticky got=%0b exp=1", overrun);
        end
    endtask

    task automatic test_clamp_reset();
        int f = frames;
        int n = 0;
        int late = 0;
        logic [15:0] w = mwr;
        logic [15:0] ex = (w == TOP) ? BASE : w + 16'd1;
        tap_delay = {16'd0, 16'd0, 16'd0, 16'hFFFF};
        clear_logs();
        strobe(16'h1111, 1'b1);
        wait_frames(f + 1);
        checks++;
        if (log_addr.size() < 2 || log_addr[1] !== ex) begin
            failures++;
            $display("FAIL clamp_addr got=%h exp=%h",
                     log_addr.size() > 1 ? log_addr[1] : 16'hxxxx, ex);
        end
        lat = 6;
        clear_logs();
        strobe(16'h2222, 1'b1);
        while (log_addr.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({m.mem_req, busy, overrun, tap_valid, frame_done, m.mem_addr} !== 21'h0) begin
            failures++;
            $display("FAIL rst_mid req=%0b busy=%0b ovr=%0b tv=%0b fd=%0b addr=%h exp all 0",
                     m.mem_req, busy, overrun, tap_valid, frame_done, m.mem_addr);
        end
        exp_req.delete();
        exp_tap.delete();
        tick();
        tick();
        rst = 1'b0;
        mwr = BASE;
        for (int c = 0; c < 12; c++) begin
            if (tap_valid) late++;
            tick();
        end
        checks++;
        if (late != 0) begin
            failures++;
            $display("FAIL late_rvalid taps=%0d exp=0", late);
        end
        lat = 1;
        f = frames;
        tap_delay = {16'd3, 16'd2, 16'd1, 16'd0};
        clear_logs();
        strobe(16'h3333, 1'b1);
        wait_frames(f + 1);
        checks++;
        if (log_addr.size() == 0 || log_addr[0] !== 16'h0200) begin
            failures++;
            $display("FAIL rst_wr_ptr got=%h exp=0200",
                     log_addr.size() ? log_addr[0] : 16'hxxxx);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]    = 16'(i) ^ 16'hA5A5;
            shadow[i] = 16'(i) ^ 16'hA5A5;
        end
        m.mem_ready = 1'b1;
        mwr = BASE;
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_freeze();
        test_clamp_reset();
        checks++;
        if (exp_req.size() != 0 || exp_tap.size() != 0) begin
            failures++;
            $display("FAIL leftover req=%0d tap=%0d exp 0 0", exp_req.size(), exp_tap.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

endmodule
